// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter. Holds the current fetch address,
// advances it by 4 under the fetch handshake, applies prioritised redirects
// (trap > branch > return > jump > sequential), predicts returns with a
// small circular return-address stack and diverts misaligned targets to
// the trap vector.
//
// Handshake: pc_out is a valid fetch address whenever pc_valid=1. The
// address is consumed on a rising edge where pc_ready=1 (and en=1), and
// pc_out then moves to the next sequential address. Redirects override the
// handshake: they replace pc_out on the next edge regardless of en/pc_ready.
module pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0100_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0100_0100,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pc_ready,
  input  logic            trap_valid,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_target,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] jal_target,
  input  logic            jal_link,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_mis;
  logic [XLEN-1:0] r_bad;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;

  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_seq_pc;
  logic [PW-1:0]   w_top_inc;
  logic            w_chk;
  logic            w_mis;
  logic            w_push;
  logic            w_pop;

  assign w_seq_pc  = r_pc + XLEN'(4);
  assign w_top_inc = r_top + PW'(1);

  // Pick the single winning event; only it may touch the RAS.
  always_comb begin
    w_next_pc = r_pc;
    w_tgt     = '0;
    w_chk     = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (r_valid) begin
      if (trap_valid) begin
        w_next_pc = TRAP_VECTOR;
      end else if (br_taken) begin
        w_chk = 1'b1;
        w_tgt = br_target;
      end else if (ret_valid) begin
        w_chk = 1'b1;
        if (r_cnt != '0) begin
          w_tgt = r_ras[r_top];
          w_pop = 1'b1;
        end else begin
          w_tgt = ret_target;
        end
      end else if (jal_valid) begin
        w_chk  = 1'b1;
        w_tgt  = jal_target;
        w_push = jal_link;
      end else if (en && pc_ready) begin
        w_next_pc = w_seq_pc;
      end
    end
    w_mis = w_chk && (w_tgt[1:0] != 2'b00);
    if (w_chk) begin
      w_next_pc = w_mis ? TRAP_VECTOR : w_tgt;
    end
  end

  // PC, valid flag, misalignment capture and RAS pointer/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_bad   <= '0;
      r_top   <= '0;
      r_cnt   <= '0;
    end else if (!r_valid) begin
      r_valid <= 1'b1;
    end else begin
      r_pc  <= w_next_pc;
      r_mis <= w_mis;
      if (w_mis) begin
        r_bad <= w_tgt;
      end
      if (w_push) begin
        r_top <= w_top_inc;
        if (r_cnt != CW'(RAS_DEPTH)) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else if (w_pop) begin
        r_top <= r_top - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // RAS storage; when full the push lands on the oldest slot (circular).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[w_top_inc] <= w_seq_pc;
    end
  end

  assign pc_out     = r_pc;
  assign pc_valid   = r_valid;
  assign misaligned = r_mis;
  assign bad_addr   = r_bad;
  assign ras_empty  = (r_cnt == '0);
  assign ras_full   = (r_cnt == CW'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed walk through the fetch PC behaviour followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0100_0000;
  localparam logic [31:0] TV = 32'h0100_0100;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pc_ready;
  logic        trap_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ret_valid;
  logic [31:0] ret_target;
  logic        jal_valid;
  logic [31:0] jal_target;
  logic        jal_link;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic        ras_empty;
  logic        ras_full;

  int n_cmp;
  int n_fail;

  // Reference model state: RAS as a queue, newest entry at the back.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_bad;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pc_ready   (pc_ready),
    .trap_valid (trap_valid),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ret_valid  (ret_valid),
    .ret_target (ret_target),
    .jal_valid  (jal_valid),
    .jal_target (jal_target),
    .jal_link   (jal_link),
    .pc_out     (pc_out),
    .pc_valid   (pc_valid),
    .misaligned (misaligned),
    .bad_addr   (bad_addr),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_bad   = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_redirect(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin
      m_pc  = TV;
      m_bad = t;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (!m_valid) begin
      m_valid = 1'b1;
      return;
    end
    m_mis = 1'b0;
    if (trap_valid) begin
      m_pc = TV;
    end else if (br_taken) begin
      model_redirect(br_target);
    end else if (ret_valid) begin
      if (m_ras.size() > 0) t = m_ras.pop_back();
      else t = ret_target;
      model_redirect(t);
    end else if (jal_valid) begin
      if (jal_link) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      model_redirect(jal_target);
    end else if (en && pc_ready) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s differs from expected", tag);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc_out"},     pc_out,               m_pc);
    chk({where, ".pc_valid"},   {31'b0, pc_valid},    {31'b0, m_valid});
    chk({where, ".misaligned"}, {31'b0, misaligned},  {31'b0, m_mis});
    chk({where, ".bad_addr"},   bad_addr,             m_bad);
    chk({where, ".ras_empty"},  {31'b0, ras_empty},   {31'b0, (m_ras.size() == 0)});
    chk({where, ".ras_full"},   {31'b0, ras_full},    {31'b0, (m_ras.size() == DEPTH)});
  endtask

  // ---------------- drivers ----------------
  task automatic clear_in();
    trap_valid = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    ret_valid = 1'b0; ret_target = 32'h0;
    jal_valid = 1'b0; jal_target = 32'h0; jal_link = 1'b0;
    en = 1'b0; pc_ready = 1'b0;
  endtask

  // One clock edge: model advances on the current inputs, DUT sampled #1 later.
  task automatic tick(input string where);
    model_step();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic do_br(input logic [31:0] t, input string where);
    clear_in(); br_taken = 1'b1; br_target = t;
    tick(where);
  endtask

  task automatic do_jal(input logic [31:0] t, input logic link, input string where);
    clear_in(); jal_valid = 1'b1; jal_target = t; jal_link = link;
    tick(where);
  endtask

  task automatic do_ret(input logic [31:0] rt, input string where);
    clear_in(); ret_valid = 1'b1; ret_target = rt;
    tick(where);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string where);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(where);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = (32'h0100_0000 | ($urandom & 32'h0000_fffc));
    if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] link_pcs [5];
    n_cmp  = 0;
    n_fail = 0;
    link_pcs = '{32'h0100_0000, 32'h0100_1000, 32'h0100_2000, 32'h0100_3000, 32'h0100_4000};
    clear_in();
    rst = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_edge");
    rst = 1'b0;

    // Reset then advance
    clear_in(); en = 1'b1; pc_ready = 1'b1;
    tick("adv0");
    chk("adv0_const", pc_out, 32'h0100_0000);
    tick("adv1");
    tick("adv2");
    chk("adv2_const", pc_out, 32'h0100_0008);
    pc_ready = 1'b0;
    tick("hold");
    chk("hold_const", pc_out, 32'h0100_0008);
    en = 1'b0; pc_ready = 1'b1;
    tick("stall");

    // Priority
    clear_in();
    trap_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0100_0200;
    jal_valid = 1'b1; jal_target = 32'h0100_0300; jal_link = 1'b1;
    tick("prio_trap");
    chk("prio_trap_const", pc_out, 32'h0100_0100);
    chk("prio_trap_ras", {31'b0, ras_empty}, 32'd1);
    trap_valid = 1'b0;
    tick("prio_br");
    chk("prio_br_const", pc_out, 32'h0100_0200);

    // RAS round trip
    do_br(32'h0100_0010, "rt_br");
    do_jal(32'h0100_0400, 1'b1, "rt_jal");
    chk("rt_jal_nonempty", {31'b0, ras_empty}, 32'd0);
    do_ret(32'h0, "rt_ret");
    chk("rt_ret_const", pc_out, 32'h0100_0014);

    // RAS overflow
    for (int i = 0; i < 5; i++) begin
      do_br(link_pcs[i], "ov_br");
      do_jal(32'h0100_8000, 1'b1, "ov_jal");
    end
    chk("ov_full", {31'b0, ras_full}, 32'd1);
    for (int i = 4; i >= 1; i--) begin
      do_ret(32'h0100_9000, "ov_ret");
      chk("ov_ret_const", pc_out, link_pcs[i] + 32'd4);
    end
    do_ret(32'h0100_9000, "ov_ret_empty");
    chk("ov_ret_empty_const", pc_out, 32'h0100_9000);

    // Misaligned branch, then a stall cycle to see the pulse drop
    do_br(32'h0100_0202, "mis_br");
    chk("mis_pc", pc_out, 32'h0100_0100);
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_bad", bad_addr, 32'h0100_0202);
    clear_in();
    tick("mis_after");
    chk("mis_drop", {31'b0, misaligned}, 32'd0);

    // Misaligned jal still pushes its link
    do_jal(32'h0100_0601, 1'b1, "mis_jal");

    // Async reset with RAS count 2
    do_jal(32'h0100_0700, 1'b1, "ar_jal");
    async_reset("async_rst");
    chk("ar_pc", pc_out, 32'h0100_0000);
    chk("ar_valid", {31'b0, pc_valid}, 32'd0);
    clear_in();
    tick("ar_wake");

    // Randomized phase
    for (int c = 0; c < 600; c++) begin
      clear_in();
      trap_valid = ($urandom_range(0, 19) == 0);
      br_taken   = ($urandom_range(0, 6) == 0);
      br_target  = rand_tgt();
      ret_valid  = ($urandom_range(0, 5) == 0);
      ret_target = rand_tgt();
      jal_valid  = ($urandom_range(0, 4) == 0);
      jal_target = rand_tgt();
      jal_link   = ($urandom_range(0, 9) < 7);
      en         = ($urandom_range(0, 9) < 7);
      pc_ready   = ($urandom_range(0, 9) < 7);
      tick("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the current fetch address and advances it sequentially under a fetch handshake. It takes prioritised redirects (trap, taken branch, return, jump), predicts returns with a small circular return-address stack (RAS), and diverts misaligned targets to the trap vector. It sits between the decode/execute redirect logic and the instruction-memory address port.

## Interface
- XLEN, 32: address width in bits.
- RESET_VECTOR, 32'h0100_0000: PC value while and after reset.
- TRAP_VECTOR, 32'h0100_0100: PC value taken on a trap or a misaligned target.
- RAS_DEPTH, 4: RAS entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sequential-advance enable; 0 = stall. Redirects are not gated by en.
- pc_ready  in  1  fetch accepts pc_out this cycle.
- trap_valid  in  1  take TRAP_VECTOR.
- br_taken  in  1  taken branch.
- br_target  in  XLEN  branch target.
- ret_valid  in  1  return instruction; pops the RAS.
- ret_target  in  XLEN  resolved return address; used only when the RAS is empty.
- jal_valid  in  1  jump.
- jal_target  in  XLEN  jump target.
- jal_link  in  1  with jal_valid: push the return address.
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  pc_out is meaningful.
- misaligned  out  1  one-cycle pulse: last redirect target was misaligned.
- bad_addr  out  XLEN  captured misaligned target.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

## Operation
- Reset (async, any time) sets:
  - pc_out=RESET_VECTOR, pc_valid=0, misaligned=0, bad_addr=0.
  - RAS count=0, top pointer=0; ras_empty=1, ras_full=0.
- First rising edge with rst=0: pc_valid←1; pc_out unchanged. pc_valid then stays 1 until the next reset.
- Next-PC priority, evaluated every edge while pc_valid=1 (highest first):
  - trap_valid → TRAP_VECTOR.
  - br_taken → br_target.
  - ret_valid → RAS top if count>0, else ret_target.
  - jal_valid → jal_target.
  - en && pc_ready → pc_out+4.
  - otherwise hold.
- Only the winning event acts; lower-priority events in the same cycle are dropped, including their RAS side effects.
- Misalignment: if a winning br, ret or jal target has bits [1:0]≠0:
  - PC←TRAP_VECTOR, bad_addr←target, misaligned=1 for exactly one cycle.
  - RAS side effects of that event still apply.
- RAS push: winning jal_valid with jal_link=1 writes pc_out+4 at top+1.
  - Count saturates at RAS_DEPTH.
  - When full, the oldest entry is silently overwritten (circular pointer).
- RAS pop: winning ret_valid with count>0 reads top, then top−1 and count−1.
  - With count==0, nothing changes in the RAS.
- Trap and branch never modify the RAS.
- Arithmetic: pc_out+4 and pointer updates wrap modulo 2^XLEN and modulo RAS_DEPTH respectively.
- Events while pc_valid=0 are ignored.

## Timing
- All outputs are registered. A redirect asserted in cycle N appears on pc_out in cycle N+1.
- Sequential advance happens on the edge where en=1 and pc_ready=1. The new PC appears the following cycle.
- Redirects apply when en=0 or pc_ready=0 (flush semantics).
- misaligned is high for the single cycle after the offending edge; bad_addr holds until the next misalignment or reset.
- ras_empty and ras_full reflect the count after the edge.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

## Test plan
- Reset then advance: release rst and hold en=1, pc_ready=1 for 3 cycles → pc_valid rises on the first edge, pc_out goes 0x01000000, 0x01000004, 0x01000008. With pc_ready=0, pc_out holds.
- Priority: in one cycle assert trap_valid, br_taken (0x01000200), jal_valid (0x01000300, link=1) → pc_out=0x01000100, RAS count stays 0. Repeat without trap → pc_out=0x01000200.
- RAS round trip: at pc_out=0x01000010, jal to 0x01000400 with link → ras_empty=0; then ret_valid with ret_target=0 → pc_out=0x01000014, ras_empty=1.
- RAS overflow: 5 linked jals from PCs 0x0100_0000, 0x0100_1000, 0x0100_2000, 0x0100_3000, 0x0100_4000 (RAS_DEPTH=4) → ras_full=1. Four rets return 0x0100_4004, 0x0100_3004, 0x0100_2004, 0x0100_1004. A fifth ret uses ret_target.
- Misaligned: br_taken with target 0x01000202 → pc_out=0x01000100, misaligned=1 for one cycle, bad_addr=0x01000202.
- Async reset mid-stream: pulse rst between edges with RAS count=2 → pc_out=0x01000000 and pc_valid=0 immediately, ras_empty=1.
